// File: rtl/vdma_vin_to_axi4s.sv
// Parallel video (vsync/de/data) to AXI4-Stream converter with a 16-deep FWFT FIFO,
// sticky overflow reporting and live frame-geometry measurement.
`timescale 1ns/1ps
module vdma_vin_to_axi4s #(
  parameter int DATA_WIDTH     = 32,
  parameter int USER_WIDTH     = 1,
  parameter int FIFO_PTR_WIDTH = 4,
  parameter int H_WIDTH        = 12,
  parameter int V_WIDTH        = 12
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  ctl_enable,
  output logic                  ctl_busy,
  output logic                  stat_overflow,
  input  logic                  stat_overflow_clear,
  output logic [7:0]            stat_frame_count,
  output logic [H_WIDTH-1:0]    monitor_width,
  output logic [V_WIDTH-1:0]    monitor_height,
  input  logic                  vin_vsync,
  input  logic                  vin_de,
  input  logic [DATA_WIDTH-1:0] vin_data,
  output logic [USER_WIDTH-1:0] m_axi4s_tuser,
  output logic                  m_axi4s_tlast,
  output logic [DATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                  m_axi4s_tvalid,
  input  logic                  m_axi4s_tready,
  output logic [1:0]            dbg_state
);
  // Stream handshake: a beat transfers on a clock edge where tvalid && tready; while
  // tvalid is high and tready low, tdata/tuser/tlast hold and tvalid stays high.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT_VSYNC = 2'd1, S_ACTIVE = 2'd2} state_t;

  localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
  localparam int PW    = FIFO_PTR_WIDTH + 1;
  localparam int EW    = USER_WIDTH + 1 + DATA_WIDTH;

  state_t                state_q, state_d;
  logic                  vsync_q, vsync_d, de_q, de_d;
  logic                  pend_valid_q, pend_valid_d, pend_sof_q, pend_sof_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                  sof_pending_q, sof_pending_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic [H_WIDTH-1:0]    h_cnt_q, h_cnt_d, mon_w_q, mon_w_d;
  logic [V_WIDTH-1:0]    v_cnt_q, v_cnt_d, mon_h_q, mon_h_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]         mem_q [DEPTH];

  logic vsync_rise, de_fall, fifo_empty, fifo_full, pop, push_ok, overflow_evt;
  logic [USER_WIDTH-1:0] push_user;
  logic [EW-1:0]         push_entry, rd_entry;

  always_comb begin
    vsync_rise   = vin_vsync & ~vsync_q;
    de_fall      = ~vin_de & de_q;
    fifo_empty   = (wr_ptr_q == rd_ptr_q);
    fifo_full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    pop          = ~fifo_empty & m_axi4s_tready;
    push_ok      = pend_valid_q & (~fifo_full | pop);
    overflow_evt = pend_valid_q & ~push_ok;
    push_user    = '0;
    push_user[0] = pend_sof_q;
    // The pending pixel ends its line when the sample arriving now has de low or starts a frame.
    push_entry   = {push_user, ~vin_de | vsync_rise, pend_data_q};
    wr_ptr_d     = wr_ptr_q + PW'(push_ok);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    vsync_d      = vin_vsync;
    de_d         = vin_de;
    overflow_d   = (overflow_q & ~stat_overflow_clear) | overflow_evt;
  end

  always_comb begin
    state_d       = state_q;
    sof_pending_d = sof_pending_q;
    frame_cnt_d   = frame_cnt_q;
    pend_valid_d  = 1'b0;
    pend_data_d   = pend_data_q;
    pend_sof_d    = pend_sof_q;
    case (state_q)
      S_IDLE: if (ctl_enable) state_d = S_WAIT_VSYNC;
      S_WAIT_VSYNC: begin
        if (!ctl_enable) begin
          state_d = S_IDLE;
        end else if (vsync_rise) begin
          state_d       = S_ACTIVE;
          sof_pending_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
        end
      end
      S_ACTIVE: begin
        if (overflow_evt) begin
          // Abandon the rest of this frame; the next vsync restarts cleanly with tuser.
          state_d = S_WAIT_VSYNC;
        end else if (vsync_rise && !ctl_enable) begin
          state_d = S_IDLE;
        end else begin
          if (vin_de) begin
            pend_valid_d  = 1'b1;
            pend_data_d   = vin_data;
            pend_sof_d    = sof_pending_q;
            sof_pending_d = 1'b0;
          end
          if (vsync_rise) begin
            sof_pending_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    mon_w_d = mon_w_q;
    v_cnt_d = v_cnt_q;
    mon_h_d = mon_h_q;
    if (de_fall) begin
      mon_w_d = h_cnt_q;
      h_cnt_d = '0;
    end else if (vin_de) begin
      h_cnt_d = h_cnt_q + H_WIDTH'(1);
    end
    if (vsync_rise) begin
      mon_h_d = v_cnt_q + V_WIDTH'(de_fall);
      v_cnt_d = '0;
    end else if (de_fall) begin
      v_cnt_d = v_cnt_q + V_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= S_IDLE;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_sof_q    <= 1'b0;
      pend_data_q   <= '0;
      sof_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      frame_cnt_q   <= '0;
      h_cnt_q       <= '0;
      mon_w_q       <= '0;
      v_cnt_q       <= '0;
      mon_h_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pend_valid_q  <= pend_valid_d;
      pend_sof_q    <= pend_sof_d;
      pend_data_q   <= pend_data_d;
      sof_pending_q <= sof_pending_d;
      overflow_q    <= overflow_d;
      frame_cnt_q   <= frame_cnt_d;
      h_cnt_q       <= h_cnt_d;
      mon_w_q       <= mon_w_d;
      v_cnt_q       <= v_cnt_d;
      mon_h_q       <= mon_h_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) mem_q[wr_ptr_q[PW-2:0]] <= push_entry;
  end

  always_comb begin
    rd_entry         = mem_q[rd_ptr_q[PW-2:0]];
    m_axi4s_tdata    = rd_entry[DATA_WIDTH-1:0];
    m_axi4s_tlast    = rd_entry[DATA_WIDTH];
    m_axi4s_tuser    = rd_entry[EW-1 -: USER_WIDTH];
    m_axi4s_tvalid   = ~fifo_empty;
    ctl_busy         = (state_q != S_IDLE);
    stat_overflow    = overflow_q;
    stat_frame_count = frame_cnt_q;
    monitor_width    = mon_w_q;
    monitor_height   = mon_h_q;
    dbg_state        = state_q;
  end
endmodule

// File: tb/tb_vdma_vin_to_axi4s.sv
// Bench for vdma_vin_to_axi4s: frame driver tasks, a line/frame beat model feeding an
// expected queue, and a stream monitor that scores every accepted beat.
`timescale 1ns/1ps
module tb_vdma_vin_to_axi4s;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        ctl_enable = 1'b0;
  logic        ctl_busy;
  logic        stat_overflow;
  logic        stat_overflow_clear = 1'b0;
  logic [7:0]  stat_frame_count;
  logic [11:0] monitor_width;
  logic [11:0] monitor_height;
  logic        vin_vsync = 1'b0;
  logic        vin_de = 1'b0;
  logic [31:0] vin_data = '0;
  logic [0:0]  m_axi4s_tuser;
  logic        m_axi4s_tlast;
  logic [31:0] m_axi4s_tdata;
  logic        m_axi4s_tvalid;
  logic        m_axi4s_tready = 1'b1;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_ready = 1'b0;
  logic [33:0] exp_q[$];

  vdma_vin_to_axi4s dut (
    .aclk(aclk), .areset(areset), .ctl_enable(ctl_enable), .ctl_busy(ctl_busy),
    .stat_overflow(stat_overflow), .stat_overflow_clear(stat_overflow_clear),
    .stat_frame_count(stat_frame_count), .monitor_width(monitor_width),
    .monitor_height(monitor_height), .vin_vsync(vin_vsync), .vin_de(vin_de),
    .vin_data(vin_data), .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready), .dbg_state(dbg_state)
  );

  always #5 aclk = ~aclk;

  // Stream monitor: scoreboard on accepted beats plus hold-stable check under backpressure.
  logic        prev_hold = 1'b0;
  logic [33:0] prev_beat = '0;
  always @(negedge aclk) begin
    logic [33:0] cur;
    logic [33:0] exp;
    cur = {m_axi4s_tuser[0], m_axi4s_tlast, m_axi4s_tdata};
    if (areset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_tests++;
        if (m_axi4s_tvalid !== 1'b1 || cur !== prev_beat) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%0b beat=%0h expected valid=1 beat=%0h",
                   m_axi4s_tvalid, cur, prev_beat);
        end
      end
      if (m_axi4s_tvalid === 1'b1 && m_axi4s_tready === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            n_fail++;
            $display("FAIL beat: got {tuser,tlast,data}=%0h expected %0h", cur, exp);
          end
        end
      end
      prev_hold = m_axi4s_tvalid && !m_axi4s_tready;
      prev_beat = cur;
    end
  end

  task automatic cyc(input logic v, input logic d, input logic [31:0] x);
    vin_vsync = v;
    vin_de    = d;
    vin_data  = x;
    if (rand_ready) m_axi4s_tready = ($urandom_range(0, 3) != 0);
    @(posedge aclk);
    #1;
  endtask

  task automatic vsync_pulse();
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
  endtask

  // Model: captured pixels become beats in order; first pixel of a captured frame carries
  // tuser, last pixel of each line carries tlast; pixels past 'limit' are dropped.
  task automatic send_lines(input int w, input int h, input int hb, input bit cap,
                            input bit sof, input int limit);
    int n;
    logic [31:0] d;
    n = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        d = $urandom;
        if (cap && n < limit)
          exp_q.push_back({sof && y == 0 && x == 0, x == w - 1, d});
        if (cap) n++;
        cyc(1'b0, 1'b1, d);
      end
      for (int b = 0; b < hb; b++) cyc(1'b0, 1'b0, '0);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic drain();
    int i;
    rand_ready = 1'b0;
    m_axi4s_tready = 1'b1;
    i = 0;
    while (i < 200 && (exp_q.size() != 0 || m_axi4s_tvalid)) begin
      cyc(1'b0, 1'b0, '0);
      i++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_tvalid", m_axi4s_tvalid, 0);
    exp_q.delete();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    check("rst_tvalid", m_axi4s_tvalid, 0);
    check("rst_busy", ctl_busy, 0);
    check("rst_overflow", stat_overflow, 0);
    check("rst_frames", stat_frame_count, 0);
    check("rst_width", monitor_width, 0);
    check("rst_height", monitor_height, 0);
    check("rst_state", dbg_state, 0);
  endtask

  task automatic test_basic();
    ctl_enable = 1'b1;
    cyc(0, 0, '0);
    cyc(0, 0, '0);
    vsync_pulse();
    send_lines(4, 3, 2, 1'b1, 1'b1, 1000);
    check("basic_frames", stat_frame_count, 1);
    check("basic_width", monitor_width, 4);
    drain();
    ctl_enable = 1'b0;
    vsync_pulse();
    check("basic_height", monitor_height, 3);
    check("basic_busy_off", ctl_busy, 0);
  endtask

  task automatic test_single_pixel();
    ctl_enable = 1'b1;
    cyc(0, 0, '0);
    cyc(0, 0, '0);
    vsync_pulse();
    send_lines(1, 2, 3, 1'b1, 1'b1, 1000);
    check("single_width", monitor_width, 1);
    check("single_frames", stat_frame_count, 2);
    drain();
  endtask

  task automatic test_enable_rise();
    ctl_enable = 1'b0;
    vsync_pulse();
    check("erise_idle", ctl_busy, 0);
    vsync_pulse();
    send_lines(4, 1, 2, 1'b0, 1'b0, 0);
    ctl_enable = 1'b1;
    send_lines(4, 2, 2, 1'b0, 1'b0, 0);
    check("erise_waiting", ctl_busy, 1);
    check("erise_no_beats", m_axi4s_tvalid, 0);
    vsync_pulse();
    send_lines(3, 2, 2, 1'b1, 1'b1, 1000);
    drain();
  endtask

  task automatic test_enable_drop();
    vsync_pulse();
    send_lines(4, 1, 2, 1'b1, 1'b1, 1000);
    ctl_enable = 1'b0;
    send_lines(4, 2, 2, 1'b1, 1'b0, 1000);
    check("edrop_busy_held", ctl_busy, 1);
    cyc(1'b1, 1'b0, '0);
    check("edrop_busy_fall", ctl_busy, 0);
    check("edrop_height", monitor_height, 3);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    send_lines(4, 2, 2, 1'b0, 1'b0, 0);
    drain();
  endtask

  task automatic test_overflow();
    ctl_enable = 1'b1;
    m_axi4s_tready = 1'b0;
    cyc(0, 0, '0);
    cyc(0, 0, '0);
    vsync_pulse();
    send_lines(8, 4, 2, 1'b1, 1'b1, 16);
    check("ovf_flag_set", stat_overflow, 1);
    check("ovf_fifo_full_valid", m_axi4s_tvalid, 1);
    drain();
    check("ovf_sticky", stat_overflow, 1);
    vsync_pulse();
    send_lines(3, 2, 2, 1'b1, 1'b1, 1000);
    drain();
    stat_overflow_clear = 1'b1;
    cyc(0, 0, '0);
    stat_overflow_clear = 1'b0;
    check("ovf_cleared", stat_overflow, 0);
  endtask

  task automatic test_back_to_back();
    int w, h, prev_h;
    prev_h = -1;
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      vsync_pulse();
      if (prev_h >= 0) check("rand_height", monitor_height, prev_h);
      send_lines(w, h, 4, 1'b1, 1'b1, 1000);
      check("rand_width", monitor_width, w);
      prev_h = h;
    end
    drain();
  endtask

  task automatic test_reset_mid_line();
    ctl_enable = 1'b1;
    m_axi4s_tready = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, $urandom);
    check("midrst_valid_before", m_axi4s_tvalid, 1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check("midrst_tvalid", m_axi4s_tvalid, 0);
    check("midrst_frames", stat_frame_count, 0);
    check("midrst_width", monitor_width, 0);
    check("midrst_busy", ctl_busy, 0);
    areset = 1'b0;
    ctl_enable = 1'b0;
    m_axi4s_tready = 1'b1;
    exp_q.delete();
    send_lines(3, 2, 2, 1'b0, 1'b0, 0);
    ctl_enable = 1'b1;
    send_lines(3, 2, 2, 1'b0, 1'b0, 0);
    check("midrst_no_capture", m_axi4s_tvalid, 0);
    vsync_pulse();
    send_lines(2, 2, 2, 1'b1, 1'b1, 1000);
    drain();
    check("midrst_frames_after", stat_frame_count, 1);
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_single_pixel();
    test_enable_rise();
    test_enable_drop();
    test_overflow();
    test_back_to_back();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
